// File: rtl/memory_pkg.sv
// ============================================================================
// Module  : memory_pkg
// Brief   : Shared constants, byte-merge helper and parameter checks for memory_mp
// Revision: 1.0
// ============================================================================
`default_nettype none

package memory_pkg;

  localparam int MAX_READ_PORTS   = 4;
  localparam int MAX_READ_LATENCY = 3;
  localparam int MAX_WIDTH        = 1024;
  localparam int MAX_BE           = MAX_WIDTH / 8;

  // Callers size-cast their words to MAX_WIDTH and back, so one helper serves any WIDTH.
  function automatic logic [MAX_WIDTH-1:0] be_merge(
    input logic [MAX_WIDTH-1:0] old_word,
    input logic [MAX_WIDTH-1:0] new_word,
    input logic [MAX_BE-1:0]    be
  );
    logic [MAX_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MAX_BE; b++) begin
      if (be[b]) begin
        merged[8*b +: 8] = new_word[8*b +: 8];
      end
    end
    return merged;
  endfunction

  function automatic bit params_ok(
    input int width,
    input int depth,
    input int ports,
    input int latency
  );
    return (width > 0) && (width % 8 == 0) && (width <= MAX_WIDTH) &&
           (depth >= 2) &&
           (ports >= 1) && (ports <= MAX_READ_PORTS) &&
           (latency >= 1) && (latency <= MAX_READ_LATENCY);
  endfunction

endpackage

`default_nettype wire

// File: rtl/memory_read_pipe.sv
// ============================================================================
// Module  : memory_read_pipe
// Brief   : Per-port read delay line; owns the read port's output registers
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_read_pipe #(
  parameter int WIDTH        = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [READ_LATENCY-1:0] r_vld;
  logic [WIDTH-1:0]        r_data [READ_LATENCY];

  // Data only advances alongside a valid, so the last stage holds between reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        r_data[s] <= '0;
      end
    end else begin
      r_vld[0] <= i_valid;
      if (i_valid) begin
        r_data[0] <= i_data;
      end
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) begin
          r_data[s] <= r_data[s-1];
        end
      end
    end
  end

  assign o_valid = r_vld[READ_LATENCY-1];
  assign o_data  = r_data[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/memory_mp.sv
// ============================================================================
// Module  : memory_mp
// Brief   : Byte-enabled 1W/NR scratch memory with configurable read latency
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_mp
  import memory_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_PORTS   = 2,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 write_en_i,
  input  logic [$clog2(DEPTH)-1:0]             write_pos_i,
  input  logic [WIDTH-1:0]                     write_data_i,
  input  logic [WIDTH/8-1:0]                   write_be_i,
  input  logic [READ_PORTS-1:0]                read_en_i,
  input  logic [READ_PORTS*$clog2(DEPTH)-1:0]  read_pos_i,
  output logic [READ_PORTS*WIDTH-1:0]          read_data_o,
  output logic [READ_PORTS-1:0]                read_valid_o
);

  localparam int              c_aw    = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_depth = (c_aw+1)'(DEPTH);

  if (!params_ok(WIDTH, DEPTH, READ_PORTS, READ_LATENCY)) begin : g_param_err
    $fatal(1, "memory_mp: illegal parameter combination");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_wr_word;

  assign w_wr_ok   = write_en_i && ({1'b0, write_pos_i} < c_depth);
  assign w_wr_word = WIDTH'(be_merge(MAX_WIDTH'(r_mem[write_pos_i]),
                                     MAX_WIDTH'(write_data_i),
                                     MAX_BE'(write_be_i)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[write_pos_i] <= w_wr_word;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [c_aw-1:0]  w_pos;
    logic             w_in_range;
    logic             w_hit;
    logic [WIDTH-1:0] w_word;

    assign w_pos      = read_pos_i[p*c_aw +: c_aw];
    assign w_in_range = ({1'b0, w_pos} < c_depth);
    // A same-address write is folded in here so write-first reads see the merged word.
    assign w_hit      = (WRITE_FIRST != 0) && w_wr_ok && (write_pos_i == w_pos);
    assign w_word     = w_in_range ? (w_hit ? w_wr_word : r_mem[w_pos]) : '0;

    memory_read_pipe #(
      .WIDTH        (WIDTH),
      .READ_LATENCY (READ_LATENCY)
    ) u_pipe (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_valid (read_en_i[p]),
      .i_data  (w_word),
      .o_valid (read_valid_o[p]),
      .o_data  (read_data_o[p*WIDTH +: WIDTH])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_mp.sv
// ============================================================================
// Module  : tb_memory_mp
// Brief   : Two memory_mp configurations driven in lockstep against a reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_mp;

  localparam int W  = 32;
  localparam int AW = 10;
  localparam int NP = 2;
  localparam int BE = W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              wen;
  logic [AW-1:0]     wpos;
  logic [W-1:0]      wdata;
  logic [BE-1:0]     wbe;
  logic [NP-1:0]     ren;
  logic [NP*AW-1:0]  rpos;
  logic [NP*W-1:0]   rdata_a, rdata_b;
  logic [NP-1:0]     rvld_a, rvld_b;

  always #5 clk = ~clk;

  memory_mp #(.WIDTH(W), .DEPTH(1024), .READ_PORTS(NP), .READ_LATENCY(1), .WRITE_FIRST(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .write_en_i(wen), .write_pos_i(wpos), .write_data_i(wdata),
    .write_be_i(wbe), .read_en_i(ren), .read_pos_i(rpos), .read_data_o(rdata_a),
    .read_valid_o(rvld_a));

  memory_mp #(.WIDTH(W), .DEPTH(1000), .READ_PORTS(NP), .READ_LATENCY(3), .WRITE_FIRST(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .write_en_i(wen), .write_pos_i(wpos), .write_data_i(wdata),
    .write_be_i(wbe), .read_en_i(ren), .read_pos_i(rpos), .read_data_o(rdata_b),
    .read_valid_o(rvld_b));

  // Reference model: per-instance word array plus a schedule of expected outputs by edge.
  int           dep [2];
  int           lat [2];
  int           wf  [2];
  logic [W-1:0] mem_m  [2][1024];
  logic         exp_v  [2][NP][8];
  logic [W-1:0] exp_d  [2][NP][8];
  logic [W-1:0] last_d [2][NP];
  int           n_edge;
  int           n_vec;
  int           n_err;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                         input logic [BE-1:0] be);
    for (int b = 0; b < BE; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  function automatic logic [W-1:0] dat(input int i, input int p);
    return (i == 0) ? rdata_a[p*W +: W] : rdata_b[p*W +: W];
  endfunction

  function automatic logic vld(input int i, input int p);
    return (i == 0) ? rvld_a[p] : rvld_b[p];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 1024; a++) mem_m[i][a] = '0;
      for (int p = 0; p < NP; p++) begin
        last_d[i][p] = '0;
        for (int s = 0; s < 8; s++) begin
          exp_v[i][p][s] = 1'b0;
          exp_d[i][p][s] = '0;
        end
      end
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < NP; p++) begin
        if (ren[p]) begin
          int           a;
          int           slot;
          logic [W-1:0] v;
          a = int'(rpos[p*AW +: AW]);
          if (a >= dep[i]) v = '0;
          else begin
            v = mem_m[i][a];
            if (wf[i] != 0 && wen && int'(wpos) == a) v = merge(v, wdata, wbe);
          end
          slot = (n_edge + lat[i] - 1) % 8;
          exp_v[i][p][slot] = 1'b1;
          exp_d[i][p][slot] = v;
        end
      end
      if (wen && int'(wpos) < dep[i]) mem_m[i][wpos] = merge(mem_m[i][wpos], wdata, wbe);
    end
  endtask

  task automatic check_outputs();
    int s;
    s = n_edge % 8;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < NP; p++) begin
        if (exp_v[i][p][s]) last_d[i][p] = exp_d[i][p][s];
        check_val($sformatf("sb_vld_i%0d_p%0d_e%0d", i, p, n_edge), W'(vld(i, p)), W'(exp_v[i][p][s]));
        check_val($sformatf("sb_dat_i%0d_p%0d_e%0d", i, p, n_edge), dat(i, p), last_d[i][p]);
        exp_v[i][p][s] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_outputs();
    n_edge++;
    @(negedge clk);
  endtask

  task automatic set_idle();
    wen = 1'b0; wbe = '0; ren = '0;
  endtask

  task automatic set_wr(input int a, input logic [W-1:0] d, input logic [BE-1:0] be);
    wen = 1'b1; wpos = AW'(a); wdata = d; wbe = be;
  endtask

  task automatic set_rd(input int p, input int a);
    ren[p] = 1'b1; rpos[p*AW +: AW] = AW'(a);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    dep = '{1024, 1000};
    lat = '{1, 3};
    wf  = '{1, 0};
    n_edge = 0; n_vec = 0; n_err = 0;
    rst = 1'b0; wpos = '0; wdata = '0; rpos = '0;
    set_idle();
    model_reset();
    #1 rst = 1'b1;
    #1 check_outputs();
    tick(); tick();
    rst = 1'b0;

    // Reset state then a read of a never-written word
    set_rd(0, 5); tick(); set_idle();
    check_val("t1_vld", W'(rvld_a[0]), 32'd1);
    check_val("t1_dat", dat(0, 0), 32'h0);

    // Partial-byte overwrite
    set_wr(3, 32'hDEADBEEF, 4'b1111); tick();
    set_wr(3, 32'h000000AA, 4'b0001); tick(); set_idle();
    set_rd(0, 3); tick(); set_idle();
    check_val("t2_merge_a", dat(0, 0), 32'hDEADBEAA);
    tick(); tick();
    check_val("t2_merge_b", dat(1, 0), 32'hDEADBEAA);

    // Read-during-write on both ports
    set_wr(7, 32'h11223344, 4'b1111); tick();
    set_wr(7, 32'hFFFFFFFF, 4'b1100); set_rd(0, 7); set_rd(1, 7); tick(); set_idle();
    check_val("t3_wfirst_p0", dat(0, 0), 32'hFFFF3344);
    check_val("t3_wfirst_p1", dat(0, 1), 32'hFFFF3344);
    tick(); tick();
    check_val("t3_rfirst_p0", dat(1, 0), 32'h11223344);
    check_val("t3_rfirst_p1", dat(1, 1), 32'h11223344);

    // Back-to-back reads through the 3-deep pipe, with a late overwrite of addr 1
    set_wr(0, 32'hA0, 4'hF); tick();
    set_wr(1, 32'hA1, 4'hF); tick();
    set_wr(2, 32'hA2, 4'hF); tick(); set_idle();
    set_rd(0, 0); tick();
    set_rd(0, 1); tick();
    set_rd(0, 2); set_wr(1, 32'h00000BAD, 4'hF); tick(); set_idle();
    check_val("t4_b_first", dat(1, 0), 32'hA0);
    tick();
    check_val("t4_b_old", dat(1, 0), 32'hA1);
    check_val("t4_b_vld", W'(rvld_b[0]), 32'd1);
    tick();
    check_val("t4_b_last", dat(1, 0), 32'hA2);

    // Reset with two reads in flight on the deep pipe
    set_rd(0, 3); set_rd(1, 7); tick();
    set_rd(0, 0); tick(); set_idle();
    reset_pulse();
    tick(); tick(); tick();
    check_val("t5_flush_vld", W'(rvld_b), 32'd0);
    set_rd(0, 3); tick(); set_idle();
    tick(); tick();
    check_val("t5_cleared", dat(1, 0), 32'h0);
    check_val("t5_cleared_vld", W'(rvld_b[0]), 32'd1);

    // Out-of-range address on the 1000-word instance
    set_wr(10, 32'h12345678, 4'hF); tick();
    set_wr(1010, 32'hCAFEF00D, 4'hF); tick(); set_idle();
    set_rd(0, 1010); set_rd(1, 10); tick(); set_idle();
    check_val("t6_a_inrange", dat(0, 0), 32'hCAFEF00D);
    tick(); tick();
    check_val("t6_oor_dat", dat(1, 0), 32'h0);
    check_val("t6_oor_vld", W'(rvld_b[0]), 32'd1);
    check_val("t6_no_alias", dat(1, 1), 32'h12345678);

    // Random traffic focused on a small address window plus out-of-range addresses
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 79) == 0) reset_pulse();
      wen   = 1'($urandom_range(0, 1));
      wpos  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(1000, 1023)) : AW'($urandom_range(0, 15));
      wdata = $urandom;
      wbe   = BE'($urandom_range(0, 15));
      for (int p = 0; p < NP; p++) begin
        ren[p] = 1'($urandom_range(0, 1));
        rpos[p*AW +: AW] = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(1000, 1023))
                                                       : AW'($urandom_range(0, 15));
      end
      tick();
    end
    set_idle();
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
